// File: rtl/player_ctl_if.sv
// Signal bundle between the button decoder / VGA timing side and the player motion controller.
// The controller takes the slave modport; the driver of buttons and vblnk takes the master modport.
interface player_ctl_if;
  logic        vblnk;
  logic        btn_left;
  logic        btn_right;
  logic        btn_jump;
  logic        freeze;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic        facing_left;
  logic        moving;
  logic        airborne;

  modport master (
    output vblnk, btn_left, btn_right, btn_jump, freeze,
    input  xpos, ypos, facing_left, moving, airborne
  );

  modport slave (
    input  vblnk, btn_left, btn_right, btn_jump, freeze,
    output xpos, ypos, facing_left, moving, airborne
  );
endinterface

// File: rtl/player_ctl.sv
// Player motion controller: once per frame (rising vblnk) applies horizontal moves, jump and gravity.
// Define PLAYER_WRAP_EN to wrap xpos around the screen edges instead of clamping.
module player_ctl #(
  parameter int SCREEN_W = 1024,
  parameter int PLAYER_W = 48,
  parameter int X_START  = 100,
  parameter int Y_GROUND = 600,
  parameter int STEP_X   = 4,
  parameter int JUMP_V0  = 16,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 16
) (
  input logic         clk,
  input logic         rst,
  player_ctl_if.slave bus
);

  typedef enum logic [1:0] {GROUND, RISE, FALL} vstate_t;

  localparam logic [11:0] X_MAX   = 12'(SCREEN_W - PLAYER_W);
  localparam logic [11:0] STEP    = 12'(STEP_X);
  localparam logic [10:0] X_RST   = 11'(X_START);
  localparam logic [10:0] Y_GND   = 11'(Y_GROUND);
  localparam logic [11:0] Y_GND12 = 12'(Y_GROUND);
  localparam logic [4:0]  V0      = 5'(JUMP_V0);
  localparam logic [4:0]  GRAV    = 5'(GRAVITY);
  localparam logic [4:0]  VMAX    = 5'(MAX_FALL);

  vstate_t     state_q, state_n;
  logic        vblnk_q;
  logic [10:0] x_q, x_n;
  logic [10:0] y_q, y_n;
  logic [4:0]  vy_q, vy_n;
  logic        facing_q, facing_n;
  logic        moving_q, moving_n;
  logic        armed_q, armed_n;
  logic        airborne_q;
  logic        upd;
  logic [11:0] x_calc;
  logic [11:0] y_calc;
  logic [5:0]  vy_sum;

  // A frame tick is consumed even when frozen; only the state update is suppressed.
  always_comb begin
    upd      = bus.vblnk & ~vblnk_q & ~bus.freeze;
    state_n  = state_q;
    x_n      = x_q;
    y_n      = y_q;
    vy_n     = vy_q;
    facing_n = facing_q;
    moving_n = moving_q;
    armed_n  = armed_q;
    x_calc   = {1'b0, x_q};
    y_calc   = {1'b0, y_q};
    vy_sum   = '0;

    if (upd) begin
      if (bus.btn_left ^ bus.btn_right) begin
        if (bus.btn_left) begin
          facing_n = 1'b1;
          if (x_calc < STEP) begin
`ifdef PLAYER_WRAP_EN
            x_calc = X_MAX;
`else
            x_calc = '0;
`endif
          end else begin
            x_calc = x_calc - STEP;
          end
        end else begin
          facing_n = 1'b0;
          x_calc   = x_calc + STEP;
          if (x_calc > X_MAX) begin
`ifdef PLAYER_WRAP_EN
            x_calc = '0;
`else
            x_calc = X_MAX;
`endif
          end
        end
        x_n      = x_calc[10:0];
        moving_n = (x_calc[10:0] != x_q);
      end else begin
        moving_n = 1'b0;
      end

      // A held jump button keeps the controller disarmed, so landing never re-launches.
      if (!bus.btn_jump) begin
        armed_n = 1'b1;
      end

      case (state_q)
        GROUND: begin
          if (bus.btn_jump && armed_q) begin
            state_n = RISE;
            vy_n    = V0;
            armed_n = 1'b0;
          end
        end
        RISE: begin
          y_calc = y_calc - {7'd0, vy_q};
          y_n    = y_calc[10:0];
          vy_n   = vy_q - GRAV;
          if (vy_n == 5'd0) begin
            state_n = FALL;
          end
        end
        FALL: begin
          vy_sum = {1'b0, vy_q} + {1'b0, GRAV};
          vy_n   = (vy_sum > {1'b0, VMAX}) ? VMAX : vy_sum[4:0];
          y_calc = y_calc + {7'd0, vy_n};
          if (y_calc >= Y_GND12) begin
            y_n     = Y_GND;
            vy_n    = '0;
            state_n = GROUND;
          end else begin
            y_n = y_calc[10:0];
          end
        end
        default: begin
          state_n = GROUND;
          vy_n    = '0;
          y_n     = Y_GND;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= GROUND;
      vblnk_q    <= 1'b0;
      x_q        <= X_RST;
      y_q        <= Y_GND;
      vy_q       <= '0;
      facing_q   <= 1'b0;
      moving_q   <= 1'b0;
      armed_q    <= 1'b1;
      airborne_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      vblnk_q    <= bus.vblnk;
      x_q        <= x_n;
      y_q        <= y_n;
      vy_q       <= vy_n;
      facing_q   <= facing_n;
      moving_q   <= moving_n;
      armed_q    <= armed_n;
      airborne_q <= (state_n != GROUND);
    end
  end

  assign bus.xpos        = x_q;
  assign bus.ypos        = y_q;
  assign bus.facing_left = facing_q;
  assign bus.moving      = moving_q;
  assign bus.airborne    = airborne_q;

endmodule
